// File: rtl/reg_file_fifo_ctrl.sv
// FIFO access controller: drives the write/read ports of a 2^N x BITS register file
// and tracks occupancy, producing a first-word-fall-through FIFO with sticky error flags.
module reg_file_fifo_ctrl #(
    parameter int unsigned N    = 2,
    parameter int unsigned BITS = 4
) (
    input  logic            CLK,
    input  logic            RESET_n,
    input  logic            wr,
    input  logic            rd,
    input  logic            clr_err,
    input  logic [BITS-1:0] data_in,
    output logic [BITS-1:0] data_w,
    output logic [N-1:0]    address_w,
    output logic            WE,
    output logic [N-1:0]    address_r,
    output logic            full,
    output logic            empty,
    output logic [N:0]      count,
    output logic            overflow,
    output logic            underflow
);

    localparam logic [N:0] Depth = (N+1)'(2 ** N);

    logic [N-1:0] wptr_q, wptr_d;
    logic [N-1:0] rptr_q, rptr_d;
    logic [N:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         do_wr, do_rd;

    // Qualify against the registered flags so a full FIFO never passes a write through.
    assign do_wr = wr & ~full_q;
    assign do_rd = rd & ~empty_q;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (do_wr) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_rd) begin
            rptr_d = rptr_q + 1'b1;
        end
        count_d = count_q + (N+1)'(do_wr) - (N+1)'(do_rd);

        full_d  = (count_d == Depth);
        empty_d = (count_d == '0);

        // A set event outranks a clear in the same cycle.
        if (wr & full_q) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end
        if (rd & empty_q) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign data_w    = data_in;
    assign WE        = do_wr;
    assign address_w = wptr_q;
    assign address_r = rptr_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
